// File: rtl/reservation_station.sv
// reservation_station
// Out-of-order holding buffer between the dispatcher and the ALU. It accepts one
// instruction per cycle, snoops both CDB channels to wake waiting operands and
// issues the lowest-index ready entry to the ALU each cycle.
// Optional feature macro: RS_WAKEUP_BYPASS_EN -- when defined, an operand whose
// tag is broadcast on the CDB in the current cycle counts as ready for selection
// and its value is forwarded straight into RSALU_Vj/RSALU_Vk.
module reservation_station #(
    parameter int RS_SIZE      = 16,
    parameter int RS_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int RoB_WIDTH    = 8,
    parameter int EX_RoB_WIDTH = 9,
    parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {(EX_RoB_WIDTH-1){1'b0}}}
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,

    input  logic                    DPRS_en,
    input  logic [ADDR_WIDTH-1:0]   DPRS_pc,
    input  logic [6:0]              DPRS_opcode,
    input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
    input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
    input  logic [31:0]             DPRS_Vj,
    input  logic [31:0]             DPRS_Vk,
    input  logic [31:0]             DPRS_imm,
    input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
    output logic                    RSDP_full,

    input  logic                    CDBRS_RS_en,
    input  logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index,
    input  logic [31:0]             CDBRS_RS_value,
    input  logic                    CDBRS_LSB_en,
    input  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index,
    input  logic [31:0]             CDBRS_LSB_value,

    input  logic                    RoBRS_pre_judge,

    output logic                    RSALU_en,
    output logic [ADDR_WIDTH-1:0]   RSALU_pc,
    output logic [6:0]              RSALU_opcode,
    output logic [31:0]             RSALU_Vj,
    output logic [31:0]             RSALU_Vk,
    output logic [31:0]             RSALU_imm,
    output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);

    // Entry storage
    logic                    busy_q   [RS_SIZE];
    logic                    busy_d   [RS_SIZE];
    logic [ADDR_WIDTH-1:0]   pc_q     [RS_SIZE];
    logic [ADDR_WIDTH-1:0]   pc_d     [RS_SIZE];
    logic [6:0]              opcode_q [RS_SIZE];
    logic [6:0]              opcode_d [RS_SIZE];
    logic [EX_RoB_WIDTH-1:0] qj_q     [RS_SIZE];
    logic [EX_RoB_WIDTH-1:0] qj_d     [RS_SIZE];
    logic [EX_RoB_WIDTH-1:0] qk_q     [RS_SIZE];
    logic [EX_RoB_WIDTH-1:0] qk_d     [RS_SIZE];
    logic [31:0]             vj_q     [RS_SIZE];
    logic [31:0]             vj_d     [RS_SIZE];
    logic [31:0]             vk_q     [RS_SIZE];
    logic [31:0]             vk_d     [RS_SIZE];
    logic [31:0]             imm_q    [RS_SIZE];
    logic [31:0]             imm_d    [RS_SIZE];
    logic [RoB_WIDTH-1:0]    rob_q    [RS_SIZE];
    logic [RoB_WIDTH-1:0]    rob_d    [RS_SIZE];

    logic [RS_WIDTH:0]       count_q;
    logic [RS_WIDTH:0]       count_d;

    // Registered issue port
    logic                    aluEn_q,  aluEn_d;
    logic [ADDR_WIDTH-1:0]   aluPc_q,  aluPc_d;
    logic [6:0]              aluOp_q,  aluOp_d;
    logic [31:0]             aluVj_q,  aluVj_d;
    logic [31:0]             aluVk_q,  aluVk_d;
    logic [31:0]             aluImm_q, aluImm_d;
    logic [RoB_WIDTH-1:0]    aluRob_q, aluRob_d;

    // Per-entry snoop results and selection-time operand view
    logic                    hitRsJ  [RS_SIZE];
    logic                    hitLsbJ [RS_SIZE];
    logic                    hitRsK  [RS_SIZE];
    logic                    hitLsbK [RS_SIZE];
    logic                    readyJ  [RS_SIZE];
    logic                    readyK  [RS_SIZE];
    logic [31:0]             fwdVj   [RS_SIZE];
    logic [31:0]             fwdVk   [RS_SIZE];

    logic                    selFound;
    logic [RS_WIDTH-1:0]     selIdx;
    logic                    freeFound;
    logic [RS_WIDTH-1:0]     freeIdx;
    logic                    allocEn;
    logic                    issueEn;

    logic                    dispHitRsJ, dispHitLsbJ, dispHitRsK, dispHitLsbK;
    logic [EX_RoB_WIDTH-1:0] dispQj, dispQk;
    logic [31:0]             dispVj, dispVk;

    // A tag matches a broadcast only when it names a real producer.
    function automatic logic cdbHit(input logic [EX_RoB_WIDTH-1:0] tag,
                                    input logic                    en,
                                    input logic [RoB_WIDTH-1:0]    idx);
        cdbHit = en && (tag != NON_DEP) && (tag[RoB_WIDTH-1:0] == idx);
    endfunction

    // Snoop both CDB channels for every entry and build the operand view used by selection.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            hitRsJ[i]  = cdbHit(qj_q[i], CDBRS_RS_en,  CDBRS_RS_RoB_index);
            hitLsbJ[i] = cdbHit(qj_q[i], CDBRS_LSB_en, CDBRS_LSB_RoB_index);
            hitRsK[i]  = cdbHit(qk_q[i], CDBRS_RS_en,  CDBRS_RS_RoB_index);
            hitLsbK[i] = cdbHit(qk_q[i], CDBRS_LSB_en, CDBRS_LSB_RoB_index);
            readyJ[i]  = (qj_q[i] == NON_DEP);
            readyK[i]  = (qk_q[i] == NON_DEP);
            fwdVj[i]   = vj_q[i];
            fwdVk[i]   = vk_q[i];
`ifdef RS_WAKEUP_BYPASS_EN
            if (!readyJ[i] && (hitRsJ[i] || hitLsbJ[i])) begin
                readyJ[i] = 1'b1;
                fwdVj[i]  = hitRsJ[i] ? CDBRS_RS_value : CDBRS_LSB_value;
            end
            if (!readyK[i] && (hitRsK[i] || hitLsbK[i])) begin
                readyK[i] = 1'b1;
                fwdVk[i]  = hitRsK[i] ? CDBRS_RS_value : CDBRS_LSB_value;
            end
`endif
        end
    end

    // Priority-pick the lowest ready entry for issue and the lowest free entry for allocation.
    always_comb begin
        selFound  = 1'b0;
        selIdx    = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!selFound && busy_q[i] && readyJ[i] && readyK[i]) begin
                selFound = 1'b1;
                selIdx   = RS_WIDTH'(i);
            end
            if (!freeFound && !busy_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = RS_WIDTH'(i);
            end
        end
        allocEn = RoBRS_pre_judge && Sys_rdy && DPRS_en && freeFound;
        issueEn = RoBRS_pre_judge && Sys_rdy && selFound;
    end

    // Resolve incoming operands against a same-cycle broadcast, RS channel first.
    always_comb begin
        dispHitRsJ  = cdbHit(DPRS_Qj, CDBRS_RS_en,  CDBRS_RS_RoB_index);
        dispHitLsbJ = cdbHit(DPRS_Qj, CDBRS_LSB_en, CDBRS_LSB_RoB_index);
        dispHitRsK  = cdbHit(DPRS_Qk, CDBRS_RS_en,  CDBRS_RS_RoB_index);
        dispHitLsbK = cdbHit(DPRS_Qk, CDBRS_LSB_en, CDBRS_LSB_RoB_index);
        dispQj = DPRS_Qj;
        dispVj = DPRS_Vj;
        dispQk = DPRS_Qk;
        dispVk = DPRS_Vk;
        if (dispHitRsJ) begin
            dispQj = NON_DEP;
            dispVj = CDBRS_RS_value;
        end else if (dispHitLsbJ) begin
            dispQj = NON_DEP;
            dispVj = CDBRS_LSB_value;
        end
        if (dispHitRsK) begin
            dispQk = NON_DEP;
            dispVk = CDBRS_RS_value;
        end else if (dispHitLsbK) begin
            dispQk = NON_DEP;
            dispVk = CDBRS_LSB_value;
        end
    end

    // Entry next state: flush wins, otherwise wakeup, free the issued slot and write the new one.
    always_comb begin
        busy_d   = busy_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        imm_d    = imm_q;
        rob_d    = rob_q;
        if (!RoBRS_pre_judge) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                busy_d[i] = 1'b0;
            end
        end else if (Sys_rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    if (hitRsJ[i]) begin
                        vj_d[i] = CDBRS_RS_value;
                        qj_d[i] = NON_DEP;
                    end else if (hitLsbJ[i]) begin
                        vj_d[i] = CDBRS_LSB_value;
                        qj_d[i] = NON_DEP;
                    end
                    if (hitRsK[i]) begin
                        vk_d[i] = CDBRS_RS_value;
                        qk_d[i] = NON_DEP;
                    end else if (hitLsbK[i]) begin
                        vk_d[i] = CDBRS_LSB_value;
                        qk_d[i] = NON_DEP;
                    end
                end
            end
            if (issueEn) begin
                busy_d[selIdx] = 1'b0;
            end
            if (allocEn) begin
                busy_d[freeIdx]   = 1'b1;
                pc_d[freeIdx]     = DPRS_pc;
                opcode_d[freeIdx] = DPRS_opcode;
                qj_d[freeIdx]     = dispQj;
                qk_d[freeIdx]     = dispQk;
                vj_d[freeIdx]     = dispVj;
                vk_d[freeIdx]     = dispVk;
                imm_d[freeIdx]    = DPRS_imm;
                rob_d[freeIdx]    = DPRS_RoB_index;
            end
        end
    end

    // Occupancy tracks allocations minus issues; a flush empties the station.
    always_comb begin
        count_d = count_q;
        if (!RoBRS_pre_judge) begin
            count_d = '0;
        end else if (Sys_rdy) begin
            count_d = count_q + (RS_WIDTH+1)'(allocEn) - (RS_WIDTH+1)'(issueEn);
        end
    end

    // Issue port next state: pulse only on a real issue, data holds otherwise.
    always_comb begin
        aluEn_d  = 1'b0;
        aluPc_d  = aluPc_q;
        aluOp_d  = aluOp_q;
        aluVj_d  = aluVj_q;
        aluVk_d  = aluVk_q;
        aluImm_d = aluImm_q;
        aluRob_d = aluRob_q;
        if (issueEn) begin
            aluEn_d  = 1'b1;
            aluPc_d  = pc_q[selIdx];
            aluOp_d  = opcode_q[selIdx];
            aluVj_d  = fwdVj[selIdx];
            aluVk_d  = fwdVk[selIdx];
            aluImm_d = imm_q[selIdx];
            aluRob_d = rob_q[selIdx];
        end
    end

    // State register for entries, occupancy and the issue port.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                busy_q[i]   <= 1'b0;
                pc_q[i]     <= '0;
                opcode_q[i] <= '0;
                qj_q[i]     <= NON_DEP;
                qk_q[i]     <= NON_DEP;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
                imm_q[i]    <= '0;
                rob_q[i]    <= '0;
            end
            count_q  <= '0;
            aluEn_q  <= 1'b0;
            aluPc_q  <= '0;
            aluOp_q  <= '0;
            aluVj_q  <= '0;
            aluVk_q  <= '0;
            aluImm_q <= '0;
            aluRob_q <= '0;
        end else begin
            busy_q   <= busy_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            qj_q     <= qj_d;
            qk_q     <= qk_d;
            vj_q     <= vj_d;
            vk_q     <= vk_d;
            imm_q    <= imm_d;
            rob_q    <= rob_d;
            count_q  <= count_d;
            aluEn_q  <= aluEn_d;
            aluPc_q  <= aluPc_d;
            aluOp_q  <= aluOp_d;
            aluVj_q  <= aluVj_d;
            aluVk_q  <= aluVk_d;
            aluImm_q <= aluImm_d;
            aluRob_q <= aluRob_d;
        end
    end

    // Full leaves one slot spare because the dispatcher sees this a cycle late.
    assign RSDP_full       = (count_q >= (RS_WIDTH+1)'(RS_SIZE - 1));
    assign RSALU_en        = aluEn_q;
    assign RSALU_pc        = aluPc_q;
    assign RSALU_opcode    = aluOp_q;
    assign RSALU_Vj        = aluVj_q;
    assign RSALU_Vk        = aluVk_q;
    assign RSALU_imm       = aluImm_q;
    assign RSALU_RoB_index = aluRob_q;

`ifndef SYNTHESIS
    // A dispatch that finds no free entry means the dispatcher ignored RSDP_full.
    allocHasRoom: assert property (@(posedge Sys_clk) disable iff (!Sys_rst)
        (DPRS_en && Sys_rdy && RoBRS_pre_judge) |-> freeFound);
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios followed by randomized
// traffic, all checked against a slot-level behavioural model of the station.
module tb_reservation_station;

    localparam logic [8:0] NON_DEP = 9'h100;
`ifdef RS_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        dpEn;
    logic [31:0] dpPc;
    logic [6:0]  dpOp;
    logic [8:0]  dpQj, dpQk;
    logic [31:0] dpVj, dpVk, dpImm;
    logic [7:0]  dpRob;
    logic        full;
    logic        rsEn, lsbEn;
    logic [7:0]  rsIdx, lsbIdx;
    logic [31:0] rsVal, lsbVal;
    logic        preJudge;
    logic        aluEn;
    logic [31:0] aluPc;
    logic [6:0]  aluOp;
    logic [31:0] aluVj, aluVk, aluImm;
    logic [7:0]  aluRob;

    int testCount = 0;
    int failCount = 0;
    logic [31:0] pcCounter = 32'h1000;

    typedef struct {
        bit          busy;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [8:0]  qj, qk;
        logic [31:0] vj, vk, imm;
        logic [7:0]  rob;
    } entry_t;

    entry_t      m[16];
    bit          expEn;
    logic [31:0] expPc, expVj, expVk, expImm;
    logic [6:0]  expOp;
    logic [7:0]  expRob;

    reservation_station dut (
        .Sys_clk(clk), .Sys_rst(rst), .Sys_rdy(rdy),
        .DPRS_en(dpEn), .DPRS_pc(dpPc), .DPRS_opcode(dpOp),
        .DPRS_Qj(dpQj), .DPRS_Qk(dpQk), .DPRS_Vj(dpVj), .DPRS_Vk(dpVk),
        .DPRS_imm(dpImm), .DPRS_RoB_index(dpRob), .RSDP_full(full),
        .CDBRS_RS_en(rsEn), .CDBRS_RS_RoB_index(rsIdx), .CDBRS_RS_value(rsVal),
        .CDBRS_LSB_en(lsbEn), .CDBRS_LSB_RoB_index(lsbIdx), .CDBRS_LSB_value(lsbVal),
        .RoBRS_pre_judge(preJudge),
        .RSALU_en(aluEn), .RSALU_pc(aluPc), .RSALU_opcode(aluOp),
        .RSALU_Vj(aluVj), .RSALU_Vk(aluVk), .RSALU_imm(aluImm),
        .RSALU_RoB_index(aluRob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [8:0] tag, input bit en, input logic [7:0] idx);
        return en && (tag != NON_DEP) && (tag[7:0] == idx);
    endfunction

    // Is an operand usable this cycle, and what value does it carry?
    function automatic bit opReady(input logic [8:0] tag);
        if (tag == NON_DEP) return 1'b1;
        return BYPASS && (hit(tag, rsEn, rsIdx) || hit(tag, lsbEn, lsbIdx));
    endfunction

    function automatic logic [31:0] opValue(input logic [8:0] tag, input logic [31:0] v);
        if (hit(tag, rsEn, rsIdx)) return rsVal;
        if (hit(tag, lsbEn, lsbIdx)) return lsbVal;
        return v;
    endfunction

    function automatic int busyCount();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m[i].busy) n++;
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
        expEn = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        int sel;
        int slot;
        expEn = 1'b0;
        if (!preJudge) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
        end else if (rdy) begin
            sel = -1;
            for (int i = 0; i < 16; i++) begin
                if (m[i].busy && opReady(m[i].qj) && opReady(m[i].qk)) begin
                    sel = i;
                    break;
                end
            end
            if (sel >= 0) begin
                expEn  = 1'b1;
                expPc  = m[sel].pc;
                expOp  = m[sel].op;
                expVj  = opValue(m[sel].qj, m[sel].vj);
                expVk  = opValue(m[sel].qk, m[sel].vk);
                expImm = m[sel].imm;
                expRob = m[sel].rob;
            end
            slot = -1;
            for (int i = 0; i < 16; i++) begin
                if (!m[i].busy) begin
                    slot = i;
                    break;
                end
            end
            for (int i = 0; i < 16; i++) begin
                if (m[i].busy) begin
                    if (hit(m[i].qj, rsEn, rsIdx) || hit(m[i].qj, lsbEn, lsbIdx)) begin
                        m[i].vj = opValue(m[i].qj, m[i].vj);
                        m[i].qj = NON_DEP;
                    end
                    if (hit(m[i].qk, rsEn, rsIdx) || hit(m[i].qk, lsbEn, lsbIdx)) begin
                        m[i].vk = opValue(m[i].qk, m[i].vk);
                        m[i].qk = NON_DEP;
                    end
                end
            end
            if (sel >= 0) m[sel].busy = 1'b0;
            if (dpEn && slot >= 0) begin
                m[slot].busy = 1'b1;
                m[slot].pc   = dpPc;
                m[slot].op   = dpOp;
                m[slot].imm  = dpImm;
                m[slot].rob  = dpRob;
                m[slot].vj   = opValue(dpQj, dpVj);
                m[slot].qj   = (opValue(dpQj, dpVj) === dpVj && !hit(dpQj, rsEn, rsIdx)
                                && !hit(dpQj, lsbEn, lsbIdx)) ? dpQj : NON_DEP;
                m[slot].vk   = opValue(dpQk, dpVk);
                m[slot].qk   = (!hit(dpQk, rsEn, rsIdx) && !hit(dpQk, lsbEn, lsbIdx)) ? dpQk : NON_DEP;
            end
        end
    endtask

    task automatic clearInputs();
        rdy = 1'b1; preJudge = 1'b1;
        dpEn = 1'b0; dpPc = '0; dpOp = '0; dpQj = NON_DEP; dpQk = NON_DEP;
        dpVj = '0; dpVk = '0; dpImm = '0; dpRob = '0;
        rsEn = 1'b0; rsIdx = '0; rsVal = '0;
        lsbEn = 1'b0; lsbIdx = '0; lsbVal = '0;
    endtask

    task automatic setDispatch(input logic [6:0] op, input logic [8:0] qj, input logic [8:0] qk,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic [31:0] imm, input logic [7:0] rob);
        dpEn = 1'b1; dpPc = pcCounter; pcCounter += 4;
        dpOp = op; dpQj = qj; dpQk = qk; dpVj = vj; dpVk = vk; dpImm = imm; dpRob = rob;
    endtask

    // Apply the current inputs across one rising edge and compare against the model.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput("en", aluEn, expEn);
        checkOutput("full", full, busyCount() >= 15);
        if (expEn) begin
            checkOutput("pc", aluPc, expPc);
            checkOutput("opcode", aluOp, expOp);
            checkOutput("Vj", aluVj, expVj);
            checkOutput("Vk", aluVk, expVk);
            checkOutput("imm", aluImm, expImm);
            checkOutput("rob", aluRob, expRob);
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        rst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rstEn", aluEn, 1'b0);
        checkOutput("rstFull", full, 1'b0);
        checkOutput("rstVj", aluVj, 32'd0);
        checkOutput("rstPc", aluPc, 32'd0);
        checkOutput("rstRob", aluRob, 8'd0);
        rst = 1'b1;

        // addi with a ready source issues one cycle after dispatch
        setDispatch(7'd13, NON_DEP, NON_DEP, 32'd5, 32'd0, 32'd3, 8'd2);
        applyStimulus();
        checkOutput("addiEarly", aluEn, 1'b0);
        applyStimulus();
        checkOutput("addiEn", aluEn, 1'b1);
        checkOutput("addiVj", aluVj, 32'd5);
        checkOutput("addiImm", aluImm, 32'd3);
        checkOutput("addiRob", aluRob, 8'd2);
        applyStimulus();
        checkOutput("addiOnce", aluEn, 1'b0);

        // add waiting on RoB 7, woken three cycles later
        setDispatch(7'd27, 9'd7, NON_DEP, 32'd0, 32'd1, 32'd0, 8'd3);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        rsEn = 1'b1; rsIdx = 8'd7; rsVal = 32'h1234;
        applyStimulus();
`ifdef RS_WAKEUP_BYPASS_EN
        checkOutput("wakeEn", aluEn, 1'b1);
        checkOutput("wakeVj", aluVj, 32'h1234);
`else
        checkOutput("wakeEarly", aluEn, 1'b0);
        applyStimulus();
        checkOutput("wakeEn", aluEn, 1'b1);
        checkOutput("wakeVj", aluVj, 32'h1234);
`endif
        applyStimulus();

        // Qk captured from a same-cycle LSB broadcast
        setDispatch(7'd28, NON_DEP, 9'd4, 32'd8, 32'd0, 32'd0, 8'd5);
        lsbEn = 1'b1; lsbIdx = 8'd4; lsbVal = 32'd9;
        applyStimulus();
        applyStimulus();
        checkOutput("capEn", aluEn, 1'b1);
        checkOutput("capVk", aluVk, 32'd9);
        applyStimulus();

        // three entries woken together issue in slot order on consecutive cycles
        for (int i = 0; i < 3; i++) begin
            setDispatch(7'd30, 9'd50, NON_DEP, 32'd0, 32'(i), 32'd0, 8'(20 + i));
            applyStimulus();
        end
        rsEn = 1'b1; rsIdx = 8'd50; rsVal = 32'h77;
        applyStimulus();
`ifndef RS_WAKEUP_BYPASS_EN
        applyStimulus();
`endif
        checkOutput("order0", aluRob, 8'd20);
        applyStimulus();
        checkOutput("order1", aluRob, 8'd21);
        applyStimulus();
        checkOutput("order2", aluRob, 8'd22);
        applyStimulus();
        checkOutput("orderDone", aluEn, 1'b0);

        // fill with blocked entries and drain past the full threshold
        for (int i = 0; i < 15; i++) begin
            setDispatch(7'd31, 9'(100 + i), NON_DEP, 32'd0, 32'd0, 32'd0, 8'(40 + i));
            applyStimulus();
        end
        checkOutput("full15", full, 1'b1);
        setDispatch(7'd31, 9'd115, NON_DEP, 32'd0, 32'd0, 32'd0, 8'd55);
        applyStimulus();
        checkOutput("full16", full, 1'b1);
        rsEn = 1'b1; rsIdx = 8'd100; rsVal = 32'd1;
        applyStimulus();
        applyStimulus();
        checkOutput("fullAt15", full, 1'b1);
        rsEn = 1'b1; rsIdx = 8'd101; rsVal = 32'd2;
        applyStimulus();
        applyStimulus();
        checkOutput("notFullAt14", full, 1'b0);
        preJudge = 1'b0;
        applyStimulus();

        // flush with ten busy entries and a coincident dispatch
        for (int i = 0; i < 10; i++) begin
            setDispatch(7'd32, 9'(120 + i), NON_DEP, 32'd0, 32'd0, 32'd0, 8'(60 + i));
            applyStimulus();
        end
        setDispatch(7'd13, NON_DEP, NON_DEP, 32'd1, 32'd1, 32'd1, 8'd99);
        preJudge = 1'b0;
        applyStimulus();
        checkOutput("flushEn", aluEn, 1'b0);
        checkOutput("flushFull", full, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rsEn = 1'b1; rsIdx = 8'(120 + 2 * i); rsVal = 32'd3;
            lsbEn = 1'b1; lsbIdx = 8'(121 + 2 * i); lsbVal = 32'd4;
            applyStimulus();
            checkOutput("flushQuiet", aluEn, 1'b0);
        end

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rdy = ($urandom_range(0, 15) != 0);
            preJudge = ($urandom_range(0, 59) != 0);
            if (busyCount() < 16 && $urandom_range(0, 9) < 6) begin
                setDispatch(7'($urandom_range(1, 37)),
                            ($urandom_range(0, 1) == 0) ? NON_DEP : 9'($urandom_range(0, 7)),
                            ($urandom_range(0, 1) == 0) ? NON_DEP : 9'($urandom_range(0, 7)),
                            $urandom, $urandom, $urandom, 8'($urandom_range(0, 255)));
            end
            rsEn = $urandom_range(0, 1) == 1;
            rsIdx = 8'($urandom_range(0, 7));
            rsVal = $urandom;
            lsbEn = $urandom_range(0, 1) == 1;
            lsbIdx = 8'($urandom_range(0, 7));
            lsbVal = $urandom;
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order holding buffer for non-memory instructions, directly downstream of the dispatcher. Each cycle it accepts at most one instruction with operand tags/values from the dispatcher and snoops both CDB channels to wake waiting operands. It issues at most one ready instruction per cycle to the ALU, and reports back-pressure to the dispatcher.

## Interface
- RS_SIZE, 16, number of entries; power of two, ≥4
- RS_WIDTH, 4, log2(RS_SIZE)
- ADDR_WIDTH, 32, pc width
- RoB_WIDTH, 8, RoB index width
- EX_RoB_WIDTH, 9, tag width; MSB set = no dependency
- NON_DEP, 9'b100000000, "operand ready" tag
---
- Sys_clk  in  1  single clock, all state on rising edge
- Sys_rst  in  1  asynchronous, active-low reset
- Sys_rdy  in  1  global enable; low = hold all state, no issue
- DPRS_en  in  1  dispatch valid this cycle
- DPRS_pc  in  ADDR_WIDTH  instruction pc
- DPRS_opcode  in  7  internal opcode enum (lui=1 … andd=37)
- DPRS_Qj / DPRS_Qk  in  EX_RoB_WIDTH  producer tags
- DPRS_Vj / DPRS_Vk  in  32  operand values (valid when tag = NON_DEP)
- DPRS_imm  in  32  immediate
- DPRS_RoB_index  in  RoB_WIDTH  destination RoB entry
- RSDP_full  out  1  back-pressure to dispatcher
- CDBRS_RS_en / CDBRS_LSB_en  in  1  CDB broadcast valid (ALU / LSB)
- CDBRS_RS_RoB_index / CDBRS_LSB_RoB_index  in  RoB_WIDTH  broadcast tag
- CDBRS_RS_value / CDBRS_LSB_value  in  32  broadcast data
- RoBRS_pre_judge  in  1  0 = mispredict, flush
- RSALU_en  out  1  issue valid (one-cycle pulse per instruction)
- RSALU_pc, RSALU_opcode, RSALU_Vj, RSALU_Vk, RSALU_imm, RSALU_RoB_index  out  as inputs  issued fields

## Operation
- Entry state: busy, pc, opcode, Qj, Qk, Vj, Vk, imm, RoB_index. Registered occupancy counter `count` (RS_WIDTH+1 bits).
- Allocation: DPRS_en writes the lowest-index non-busy entry. DPRS_en with no free entry is a protocol violation (simulation assertion); the instruction is dropped.
- Wakeup: for each busy entry, for each operand with tag ≠ NON_DEP, a CDB channel with en=1 and index == tag[RoB_WIDTH-1:0] loads Vx ← value, Qx ← NON_DEP. If both channels match the same tag, RS channel wins.
- Dispatch-cycle capture: an incoming operand tag matching a same-cycle CDB broadcast is stored as ready with the CDB value.
- Select: lowest-index entry with busy=1, Qj=Qk=NON_DEP (state at start of cycle). The selected entry is freed at the same edge its fields are registered onto RSALU_*.
- count ← count + alloc − issue; simultaneous alloc and issue leave count unchanged.
- RSDP_full = (count ≥ RS_SIZE−1), combinational from the register. This reserves one slot for the dispatcher's registered, one-cycle-late DPRS_en.
- Flush: RoBRS_pre_judge=0 at a rising edge clears all busy bits, count←0, RSALU_en←0. Same-edge dispatch and issue are discarded. Flush has priority over Sys_rdy.
- Sys_rdy=0: no alloc, wakeup, or issue. RSALU_en←0. Entries hold.

## Timing
- Reset (Sys_rst=0, asynchronous): all busy=0, count=0, RSALU_en=0, all RSALU_* data=0, so RSDP_full=0.
- Dispatch to earliest issue: written at edge N, selectable at edge N+1, RSALU_en high in cycle N+1→N+2.
- Wakeup to issue (macro off): CDB at edge N updates the entry, issue at N+1.
- RSALU_en is registered and pulses one cycle per issued instruction. Back-to-back issue on consecutive cycles is allowed.
- RSDP_full updates one cycle after the count change.

## Configuration
- RS_WAKEUP_BYPASS_EN defined: selection also treats an operand as ready if its tag matches a same-cycle CDB broadcast. The CDB value is forwarded directly into RSALU_Vj/Vk, so a CDB at edge N issues at edge N.
- RS_WAKEUP_BYPASS_EN undefined: selection uses only stored ready state, giving one extra cycle of wakeup latency.

## Test plan
- Reset then dispatch addi (Qj=NON_DEP, Vj=5, imm=3, RoB 2): RSALU_en one cycle later with Vj=5, imm=3, RoB_index=2. count returns to 0.
- Dispatch add with Qj=RoB 7. Three cycles later, CDB RS channel broadcasts index 7, value 0x1234: issue with Vj=0x1234, one cycle after broadcast (macro off) or same edge (macro on).
- Dispatch with Qk=RoB 4 in the same cycle as an LSB CDB broadcast of 4, value 9: entry stored ready with Vk=9 and issues next edge.
- Fill 15 blocked entries: RSDP_full=1 at count=15. A 16th in-flight dispatch is accepted. Waking one entry issues it and RSDP_full drops only when count ≤14.
- Three ready entries in slots 0, 1, 2: issues occur on three consecutive cycles in order 0, 1, 2.
- 10 busy entries and pre_judge=0 coincident with DPRS_en: after the edge count=0, RSALU_en=0, RSDP_full=0, and nothing issues afterward.
